// File: rtl/burst_pkg.sv
// Shared types and constants for the debug-bus burst reader.
package burst_pkg;

    localparam int unsigned BURST_WORDS      = 4;
    localparam int unsigned OCTETS_PER_BURST = 32;
    localparam int unsigned ADDR_STEP        = 8;

    localparam logic [4:0] REG_ADDR_HI  = 5'd1;
    localparam logic [4:0] REG_ADDR_MID = 5'd2;
    localparam logic [4:0] REG_ADDR_LO  = 5'd3;
    localparam logic [4:0] REG_DATA     = 5'd4;
    localparam logic [4:0] REG_STATUS   = 5'd5;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StFill,
        StReady
    } state_e;

endpackage

// File: rtl/burst_word_buffer.sv
// Burst storage: one 64-bit write port, big-endian octet read port.
module burst_word_buffer
    import burst_pkg::*;
(
    input  logic        clk,
    input  logic        i_wr_en,
    input  logic [1:0]  i_wr_idx,
    input  logic [63:0] i_wr_data,
    input  logic [4:0]  i_rd_octet,
    output logic [7:0]  o_rd_octet
);

    logic [63:0] r_mem [BURST_WORDS];
    logic [63:0] w_word;
    logic [2:0]  w_lane;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Octet 0 of a word is its most significant byte.
    always_comb begin
        w_word     = r_mem[i_rd_octet[4:3]];
        w_lane     = ~i_rd_octet[2:0];
        o_rd_octet = w_word[{w_lane, 3'b000} +: 8];
    end

endmodule

// File: rtl/burst_reader.sv
// Debug-bus driven memory burst reader. Optional sequential streaming after the
// last octet is enabled by defining BURST_READER_PREFETCH_EN.
module burst_reader #(
    parameter logic [7:0]  CHIP_SEL    = 8'h0b,
    parameter int unsigned BURST_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dbus_addr,
    input  logic [7:0]  dbus_write_data,
    input  logic        dbus_write_enable,
    input  logic        dbus_read_enable,
    output logic [7:0]  dbus_read_data,
    output logic        mem_cmd,
    output logic        mem_cmd_en,
    output logic [20:0] mem_addr,
    output logic [7:0]  mem_data_mask,
    input  logic        mem_ready,
    input  logic [63:0] mem_rd_data,
    input  logic        mem_rd_data_valid
);

    import burst_pkg::*;

`ifdef BURST_READER_PREFETCH_EN
    localparam bit PREFETCH_EN = 1'b1;
`else
    localparam bit PREFETCH_EN = 1'b0;
`endif

    state_e      r_state, w_state_next;
    logic [20:0] r_mem_addr;
    logic [20:0] r_stage;
    logic [4:0]  r_rd_idx;
    logic [1:0]  r_fill_cnt;
    logic        r_pending;
    logic        r_data_valid;
    logic [7:0]  r_rd_data;

    logic        w_sel, w_wr, w_rd, w_wr_lo;
    logic [4:0]  w_off;
    logic [20:0] w_stage_next;
    logic [20:0] w_addr_inc;
    logic        w_rd_octet, w_rd_last;
    logic        w_word_we, w_last_word, w_relaunch;
    logic [7:0]  w_buf_octet;
    logic [7:0]  w_rd_mux;
    logic        w_busy;
    logic        w_unused;

    assign w_unused = ^dbus_addr[7:5];

    assign w_sel      = (dbus_addr[15:8] == CHIP_SEL);
    assign w_off      = dbus_addr[4:0];
    assign w_wr       = w_sel && dbus_write_enable;
    assign w_rd       = w_sel && dbus_read_enable;
    assign w_wr_lo    = w_wr && (w_off == REG_ADDR_LO);
    assign w_rd_octet = w_rd && (w_off == REG_DATA) && (r_state == StReady);
    assign w_rd_last  = w_rd_octet && (r_rd_idx == 5'(OCTETS_PER_BURST - 1));
    assign w_word_we  = (r_state == StFill) && mem_rd_data_valid;
    assign w_last_word = w_word_we && (r_fill_cnt == 2'(BURST_WORDS - 1));
    // A pending (or same-cycle) register-3 write discards the burst being filled.
    assign w_relaunch = w_last_word && (r_pending || w_wr_lo);
    assign w_addr_inc = r_mem_addr + 21'(ADDR_STEP);
    assign w_busy     = (r_state == StReq) || (r_state == StFill);

    // Address writes land in a staging register so an outstanding command stays stable.
    always_comb begin
        w_stage_next = r_stage;
        if (w_wr && (w_off == REG_ADDR_HI))  w_stage_next[20:16] = dbus_write_data[4:0];
        if (w_wr && (w_off == REG_ADDR_MID)) w_stage_next[15:8]  = dbus_write_data;
        if (w_wr_lo)                         w_stage_next[7:0]   = dbus_write_data;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_wr_lo) w_state_next = StReq;
            StReq:   if (mem_ready) w_state_next = StFill;
            StFill: begin
                if (w_last_word) w_state_next = w_relaunch ? StReq : StReady;
            end
            StReady: begin
                if (w_wr_lo)        w_state_next = StReq;
                else if (w_rd_last) w_state_next = PREFETCH_EN ? StReq : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_rd_mux = 8'h00;
        if (w_off == REG_DATA) begin
            w_rd_mux = (r_state == StReady) ? w_buf_octet : 8'h00;
        end else if (w_off == REG_STATUS) begin
            w_rd_mux = {6'b0, r_data_valid, w_busy};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr   <= '0;
            r_stage      <= '0;
            r_rd_idx     <= '0;
            r_fill_cnt   <= '0;
            r_pending    <= 1'b0;
            r_data_valid <= 1'b0;
            r_rd_data    <= 8'h00;
        end else begin
            r_stage <= w_rd_last ? w_addr_inc : w_stage_next;

            if (w_wr_lo && ((r_state == StIdle) || (r_state == StReady))) begin
                r_mem_addr <= w_stage_next;
            end else if (w_relaunch) begin
                r_mem_addr <= w_stage_next;
            end else if (w_rd_last) begin
                r_mem_addr <= w_addr_inc;
            end

            if (w_last_word) begin
                r_pending <= 1'b0;
            end else if (w_wr_lo && w_busy) begin
                r_pending <= 1'b1;
            end

            if (r_state == StReq) begin
                r_fill_cnt <= '0;
            end else if (w_word_we) begin
                r_fill_cnt <= r_fill_cnt + 2'd1;
            end

            if (w_last_word && !w_relaunch) begin
                r_data_valid <= 1'b1;
            end else if (w_rd_last || ((r_state == StReady) && w_wr_lo)) begin
                r_data_valid <= 1'b0;
            end

            if (w_wr_lo) begin
                r_rd_idx <= '0;
            end else if (w_rd_octet) begin
                r_rd_idx <= r_rd_idx + 5'd1;
            end

            if (w_rd) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    burst_word_buffer u_buffer (
        .clk        (clk),
        .i_wr_en    (w_word_we),
        .i_wr_idx   (r_fill_cnt),
        .i_wr_data  (mem_rd_data),
        .i_rd_octet (r_rd_idx),
        .o_rd_octet (w_buf_octet)
    );

    assign dbus_read_data = r_rd_data;
    assign mem_cmd        = 1'b0;
    assign mem_cmd_en     = (r_state == StReq);
    assign mem_addr       = r_mem_addr;
    assign mem_data_mask  = 8'h00;

endmodule

// File: tb/tb_burst_reader.sv
// Directed self-checking bench for burst_reader (default or prefetch build).
module tb_burst_reader;

    localparam logic [7:0] CHIP = 8'h0b;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dbus_addr;
    logic [7:0]  dbus_write_data;
    logic        dbus_write_enable;
    logic        dbus_read_enable;
    logic [7:0]  dbus_read_data;
    logic        mem_cmd;
    logic        mem_cmd_en;
    logic [20:0] mem_addr;
    logic [7:0]  mem_data_mask;
    logic        mem_ready;
    logic [63:0] mem_rd_data;
    logic        mem_rd_data_valid;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rd;

    burst_reader #(
        .CHIP_SEL    (CHIP),
        .BURST_WORDS (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .dbus_addr         (dbus_addr),
        .dbus_write_data   (dbus_write_data),
        .dbus_write_enable (dbus_write_enable),
        .dbus_read_enable  (dbus_read_enable),
        .dbus_read_data    (dbus_read_data),
        .mem_cmd           (mem_cmd),
        .mem_cmd_en        (mem_cmd_en),
        .mem_addr          (mem_addr),
        .mem_data_mask     (mem_data_mask),
        .mem_ready         (mem_ready),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_data_valid (mem_rd_data_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dbus_write(input logic [4:0] off, input logic [7:0] data);
        dbus_addr         = {CHIP, 3'b000, off};
        dbus_write_data   = data;
        dbus_write_enable = 1'b1;
        tick();
        dbus_write_enable = 1'b0;
    endtask

    task automatic dbus_read(input logic [4:0] off, output logic [7:0] data);
        dbus_addr        = {CHIP, 3'b000, off};
        dbus_read_enable = 1'b1;
        tick();
        dbus_read_enable = 1'b0;
        data             = dbus_read_data;
    endtask

    function automatic logic [63:0] mk_word(input logic [7:0] base);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[63 - 8 * b -: 8] = base + 8'(b);
        return w;
    endfunction

    // Words k = first..last of a burst whose octet 0 is base, with idle gaps.
    task automatic send_words(input logic [7:0] base, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            mem_rd_data       = mk_word(base + 8'(8 * k));
            mem_rd_data_valid = 1'b1;
            tick();
            mem_rd_data_valid = 1'b0;
            mem_rd_data       = '0;
            for (int g = 0; g <= (k % 3); g++) tick();
        end
    endtask

    task automatic handshake();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic consume(input string tag, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            dbus_read(5'd4, rd);
            check(tag, 32'(rd), 32'(base + 8'(i)));
        end
    endtask

    initial begin
        reset             = 1'b1;
        dbus_addr         = '0;
        dbus_write_data   = '0;
        dbus_write_enable = 1'b0;
        dbus_read_enable  = 1'b0;
        mem_ready         = 1'b0;
        mem_rd_data       = '0;
        mem_rd_data_valid = 1'b0;
        tick();
        tick();
        check("rst_cmd_en", 32'(mem_cmd_en), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_rdata", 32'(dbus_read_data), 32'h0);
        check("rst_mask", 32'(mem_data_mask), 32'h0);
        reset = 1'b0;
        tick();
        dbus_read(5'd5, rd);
        check("rst_status", 32'(rd), 32'h00);

        // First fetch: ready arrives on the third REQ cycle.
        dbus_write(5'd1, 8'h01);
        dbus_write(5'd2, 8'h23);
        check("idle_no_cmd", 32'(mem_cmd_en), 32'h0);
        dbus_write(5'd3, 8'h45);
        check("req_cmd_en", 32'(mem_cmd_en), 32'h1);
        check("req_addr", 32'(mem_addr), 32'h012345);
        check("req_cmd", 32'(mem_cmd), 32'h0);
        tick();
        check("req_hold1", 32'(mem_cmd_en), 32'h1);
        tick();
        check("req_hold2", 32'(mem_cmd_en), 32'h1);
        handshake();
        check("hs_cmd_drop", 32'(mem_cmd_en), 32'h0);
        dbus_read(5'd5, rd);
        check("fill_status", 32'(rd), 32'h01);
        dbus_read(5'd4, rd);
        check("early_octet", 32'(rd), 32'h00);
        dbus_read(5'd0, rd);
        check("reg0_read", 32'(rd), 32'h00);

        send_words(8'h00, 0, 3);
        dbus_read(5'd5, rd);
        check("ready_status", 32'(rd), 32'h02);
        consume("burst1_octet", 8'h00, 32);
        check("wrap_addr_inc", 32'(mem_addr), 32'h01234D);
`ifdef BURST_READER_PREFETCH_EN
        check("prefetch_cmd_en", 32'(mem_cmd_en), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`else
        check("idle_cmd_en", 32'(mem_cmd_en), 32'h0);
        dbus_read(5'd5, rd);
        check("idle_status", 32'(rd), 32'h00);
`endif

        // Address wrap at the top of the 21-bit space.
        dbus_write(5'd1, 8'h1F);
        dbus_write(5'd2, 8'hFF);
        dbus_write(5'd3, 8'hFC);
        check("top_addr", 32'(mem_addr), 32'h1FFFFC);
        handshake();
        send_words(8'h20, 0, 3);
        consume("top_octet", 8'h20, 32);
        check("wrapped_addr", 32'(mem_addr), 32'h000004);
`ifdef BURST_READER_PREFETCH_EN
        check("wrap_prefetch_en", 32'(mem_cmd_en), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`else
        check("wrap_cmd_en", 32'(mem_cmd_en), 32'h0);
        dbus_read(5'd5, rd);
        check("wrap_status", 32'(rd), 32'h00);
`endif

        // Register-3 write mid-FILL: first burst is discarded.
        dbus_write(5'd1, 8'h00);
        dbus_write(5'd2, 8'h10);
        dbus_write(5'd3, 8'h00);
        handshake();
        send_words(8'h80, 0, 1);
        dbus_write(5'd3, 8'h20);
        check("pend_addr_hold", 32'(mem_addr), 32'h001000);
        check("pend_cmd_low", 32'(mem_cmd_en), 32'h0);
        send_words(8'h80, 2, 3);
        check("relaunch_cmd_en", 32'(mem_cmd_en), 32'h1);
        check("relaunch_addr", 32'(mem_addr), 32'h001020);
        dbus_read(5'd5, rd);
        check("relaunch_status", 32'(rd), 32'h01);
        handshake();
        send_words(8'h40, 0, 3);
        consume("burst2_octet", 8'h40, 4);

        // Register-3 write in READY, then reset mid-FILL with a stray word.
        dbus_write(5'd3, 8'h40);
        check("ready_rearm_cmd", 32'(mem_cmd_en), 32'h1);
        check("ready_rearm_addr", 32'(mem_addr), 32'h001040);
        handshake();
        send_words(8'hC0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_rd_data       = 64'hFFFF_FFFF_FFFF_FFFF;
        mem_rd_data_valid = 1'b1;
        tick();
        mem_rd_data_valid = 1'b0;
        check("rstfill_cmd_en", 32'(mem_cmd_en), 32'h0);
        check("rstfill_addr", 32'(mem_addr), 32'h0);
        dbus_read(5'd5, rd);
        check("rstfill_status", 32'(rd), 32'h00);
        dbus_read(5'd4, rd);
        check("rstfill_octet", 32'(rd), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
